// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Game-side score producer for the two-digit score display.
//               Synchronizes and debounces the dance-pad lanes, opens a
//               per-lane judgment window on each note_due pulse, grades
//               presses as perfect / good / miss, and accumulates a
//               saturating score and combo under an IDLE/PLAYING/DONE FSM.
// Ports       : clk, reset (async, active-high)
//               pad_raw[LANES]   raw pad switches (asynchronous)
//               note_due[LANES]  arrow-at-target pulses from the sequencer
//               start, song_end  song control pulses
//               score[9], combo[8]                      registered totals
//               hit_pulse/perfect_pulse/miss_pulse      per-lane judgments
//               playing                                  high in PLAYING
// Revision    : 1.0  initial release
// ============================================================================
module score_keeper #(
    parameter int LANES           = 4,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int WINDOW_CYCLES   = 4000000,
    parameter int PERFECT_CYCLES  = 1600000,
    parameter int MAX_SCORE       = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] pad_raw,
    input  logic [LANES-1:0] note_due,
    input  logic             start,
    input  logic             song_end,
    output logic [8:0]       score,
    output logic [7:0]       combo,
    output logic [LANES-1:0] hit_pulse,
    output logic [LANES-1:0] perfect_pulse,
    output logic [LANES-1:0] miss_pulse,
    output logic             playing
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int PW = $clog2(2 * LANES + 1);
    localparam int HW = $clog2(LANES + 1);

    localparam logic [CW-1:0] c_db_last  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] c_age_last = AW'(WINDOW_CYCLES - 1);
    localparam logic [AW-1:0] c_perfect  = AW'(PERFECT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [LANES-1:0] db_q, db_d, db_prev_q, db_prev_d;
    logic [CW-1:0]    cnt_q [LANES];
    logic [CW-1:0]    cnt_d [LANES];
    logic [LANES-1:0] open_q, open_d;
    logic [AW-1:0]    age_q [LANES];
    logic [AW-1:0]    age_d [LANES];
    logic [LANES-1:0] hit_q, hit_d, perf_q, perf_d, miss_q, miss_d;
    logic [8:0]       score_q, score_d;
    logic [7:0]       combo_q, combo_d;
    logic             playing_q, playing_d;

    logic [LANES-1:0] press;
    logic             clear_game, close_all, judge_en;
    logic [PW-1:0]    pts;
    logic [HW-1:0]    hits;
    logic [9:0]       score_sum;
    logic [8:0]       combo_sum;

    // Input conditioning: 2-FF synchronizer then per-lane stability counter.
    always_comb begin
        sync1_d   = pad_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == c_db_last) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press = db_q & ~db_prev_q;
    end

    // Game FSM. start takes priority over song_end in every state.
    always_comb begin
        state_d    = state_q;
        clear_game = 1'b0;
        close_all  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_PLAYING;
                    clear_game = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (start) begin
                    clear_game = 1'b1;
                end else if (song_end) begin
                    state_d   = ST_DONE;
                    close_all = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d    = ST_PLAYING;
                    clear_game = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        playing_d = (state_d == ST_PLAYING);
        // Judgments are dropped on the cycle the game is cleared or ended.
        judge_en  = (state_q == ST_PLAYING) && !clear_game && !close_all;
    end

    // Per-lane windows, judgments and score/combo arithmetic.
    always_comb begin
        open_d    = open_q;
        hit_d     = '0;
        perf_d    = '0;
        miss_d    = '0;
        pts       = '0;
        hits      = '0;
        score_d   = score_q;
        combo_d   = combo_q;
        for (int i = 0; i < LANES; i++) begin
            age_d[i] = age_q[i];
            if (judge_en) begin
                hit_d[i]  = open_q[i] & press[i];
                perf_d[i] = open_q[i] & press[i] & (age_q[i] < c_perfect);
                // A new note on an open window judges the old one now.
                miss_d[i] = open_q[i] & ~press[i] &
                            (note_due[i] | (age_q[i] == c_age_last));
                if (note_due[i]) begin
                    open_d[i] = 1'b1;
                    age_d[i]  = '0;
                end else if (hit_d[i] | miss_d[i]) begin
                    open_d[i] = 1'b0;
                    age_d[i]  = '0;
                end else if (open_q[i]) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end else if (clear_game | close_all) begin
                open_d[i] = 1'b0;
                age_d[i]  = '0;
            end
            if (hit_d[i]) begin
                pts  = pts + (perf_d[i] ? PW'(2) : PW'(1));
                hits = hits + HW'(1);
            end
        end

        score_sum = {1'b0, score_q} + 10'(pts);
        combo_sum = {1'b0, combo_q} + 9'(hits);
        if (clear_game) begin
            score_d = '0;
            combo_d = '0;
        end else if (judge_en) begin
            score_d = (score_sum > 10'(MAX_SCORE)) ? 9'(MAX_SCORE) : score_sum[8:0];
            if (|miss_d) begin
                combo_d = '0;
            end else begin
                combo_d = (combo_sum > 9'd255) ? 8'hFF : combo_sum[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            open_q    <= '0;
            hit_q     <= '0;
            perf_q    <= '0;
            miss_q    <= '0;
            score_q   <= '0;
            combo_q   <= '0;
            playing_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            open_q    <= open_d;
            hit_q     <= hit_d;
            perf_q    <= perf_d;
            miss_q    <= miss_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
            playing_q <= playing_d;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign score         = score_q;
    assign combo         = combo_q;
    assign hit_pulse     = hit_q;
    assign perfect_pulse = perf_q;
    assign miss_pulse    = miss_q;
    assign playing       = playing_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Self-checking bench for score_keeper. Directed stimulus pushes
//               hand-computed expected judgments (cycle, pulses, score, combo)
//               into a queue; a monitor pops and compares whenever the DUT
//               shows any judgment pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pad_raw = '0;
    logic [3:0] note_due = '0;
    logic       start = 1'b0;
    logic       song_end = 1'b0;
    logic [8:0] score;
    logic [7:0] combo;
    logic [3:0] hit_pulse, perfect_pulse, miss_pulse;
    logic       playing;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] hit;
        logic [3:0] perf;
        logic [3:0] miss;
        logic [8:0] score;
        logic [7:0] combo;
    } exp_t;

    exp_t exp_q[$];

    score_keeper #(
        .LANES(4), .DEBOUNCE_CYCLES(4), .WINDOW_CYCLES(20),
        .PERFECT_CYCLES(8), .MAX_SCORE(99)
    ) dut (
        .clk(clk), .reset(reset), .pad_raw(pad_raw), .note_due(note_due),
        .start(start), .song_end(song_end), .score(score), .combo(combo),
        .hit_pulse(hit_pulse), .perfect_pulse(perfect_pulse),
        .miss_pulse(miss_pulse), .playing(playing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every judgment pulse must match the head of the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if ((hit_pulse | perfect_pulse | miss_pulse) != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d hit=%b perf=%b miss=%b score=%0d combo=%0d",
                         cyc, hit_pulse, perfect_pulse, miss_pulse, score, combo);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || hit_pulse != e.hit || perfect_pulse != e.perf ||
                    miss_pulse != e.miss || score != e.score || combo != e.combo) begin
                    errors++;
                    $display("FAIL judgment got cyc=%0d hit=%b perf=%b miss=%b score=%0d combo=%0d expected cyc=%0d hit=%b perf=%b miss=%b score=%0d combo=%0d",
                             cyc, hit_pulse, perfect_pulse, miss_pulse, score, combo,
                             e.cyc, e.hit, e.perf, e.miss, e.score, e.combo);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] h, input logic [3:0] p,
                        input logic [3:0] m, input int s, input int cb);
        exp_t e;
        e.cyc = c; e.hit = h; e.perf = p; e.miss = m;
        e.score = 9'(s); e.combo = 8'(cb);
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Issue note_due=nmask (window opens at edge n); raise pmask so that its
    // press event is seen at window age 'age' (needs age >= 5). Returns at
    // the negedge where cyc == n (or later once the pad is raised).
    task automatic note_press(input logic [3:0] nmask, input logic [3:0] pmask,
                              input int age, output int n);
        n = cyc + 1;
        note_due = nmask;
        if (pmask != 4'b0 && age == 5) pad_raw = pad_raw | pmask;
        @(negedge clk);
        note_due = '0;
        if (pmask != 4'b0 && age > 5) begin
            wait_until(n + age - 6);
            pad_raw = pad_raw | pmask;
        end
    endtask

    task automatic release_pads();
        pad_raw = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ctrl(input logic s, input logic e);
        start = s;
        song_end = e;
        @(negedge clk);
        start = 1'b0;
        song_end = 1'b0;
    endtask

    initial begin
        int n;
        int n2;
        // Reset state
        #1;
        chk("reset_score", score, 0);
        chk("reset_combo", combo, 0);
        chk("reset_pulses", {hit_pulse, perfect_pulse, miss_pulse}, 0);
        chk("reset_playing", playing, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ctrl(1'b1, 1'b0);
        chk("start_playing", playing, 1);

        // Debounce: 3-cycle high, two 1-cycle glitches, then stable high.
        note_press(4'b0001, 4'b0000, 0, n);
        pad_raw[0] = 1'b1;
        wait_until(n + 3); pad_raw[0] = 1'b0;
        wait_until(n + 4); pad_raw[0] = 1'b1;
        wait_until(n + 5); pad_raw[0] = 1'b0;
        wait_until(n + 6); pad_raw[0] = 1'b1;
        push(n + 13, 4'b0001, 4'b0000, 4'b0000, 1, 1);
        wait_until(n + 14);
        release_pads();
        chk("debounce_score", score, 1);

        // Restart clears score and combo
        ctrl(1'b1, 1'b0);
        chk("restart_score", score, 0);
        chk("restart_combo", combo, 0);

        // Perfect / good boundaries on lane 1
        note_press(4'b0010, 4'b0010, 5, n);
        push(n + 6, 4'b0010, 4'b0010, 4'b0000, 2, 1);
        wait_until(n + 7); release_pads();
        note_press(4'b0010, 4'b0010, 12, n);
        push(n + 13, 4'b0010, 4'b0000, 4'b0000, 3, 2);
        wait_until(n + 14); release_pads();
        note_press(4'b0010, 4'b0010, 8, n);
        push(n + 9, 4'b0010, 4'b0000, 4'b0000, 4, 3);
        wait_until(n + 10); release_pads();
        note_press(4'b0010, 4'b0010, 7, n);
        push(n + 8, 4'b0010, 4'b0010, 4'b0000, 6, 4);
        wait_until(n + 9); release_pads();

        // Miss on lane 2, then a press at the last window cycle
        note_press(4'b0100, 4'b0000, 0, n);
        push(n + 20, 4'b0000, 4'b0000, 4'b0100, 6, 0);
        wait_until(n + 21);
        note_press(4'b0100, 4'b0100, 19, n);
        push(n + 20, 4'b0100, 4'b0000, 4'b0000, 7, 1);
        wait_until(n + 21); release_pads();

        // All four lanes perfect together
        note_press(4'b1111, 4'b1111, 5, n);
        push(n + 6, 4'b1111, 4'b1111, 4'b0000, 15, 5);
        wait_until(n + 7); release_pads();

        // Lane 0 good hit and lane 3 expiry on the same cycle
        note_press(4'b1001, 4'b0001, 19, n);
        push(n + 20, 4'b0001, 4'b0000, 4'b1000, 16, 0);
        wait_until(n + 21); release_pads();

        // Preload towards saturation
        for (int k = 1; k <= 10; k++) begin
            note_press(4'b1111, 4'b1111, 5, n);
            push(n + 6, 4'b1111, 4'b1111, 4'b0000, 16 + 8 * k, 4 * k);
            wait_until(n + 7); release_pads();
        end
        note_press(4'b0001, 4'b0001, 12, n);
        push(n + 13, 4'b0001, 4'b0000, 4'b0000, 97, 41);
        wait_until(n + 14); release_pads();
        note_press(4'b0011, 4'b0011, 5, n);
        push(n + 6, 4'b0011, 4'b0011, 4'b0000, 99, 43);
        wait_until(n + 7); release_pads();
        note_press(4'b1111, 4'b1111, 5, n);
        push(n + 6, 4'b1111, 4'b1111, 4'b0000, 99, 47);
        wait_until(n + 7); release_pads();

        // Overlapping notes on lane 0, no press
        note_press(4'b0001, 4'b0000, 0, n);
        wait_until(n + 9);
        push(n + 10, 4'b0000, 4'b0000, 4'b0001, 99, 0);
        push(n + 30, 4'b0000, 4'b0000, 4'b0001, 99, 0);
        note_press(4'b0001, 4'b0000, 0, n2);
        chk("overlap_second_note_cycle", n2, n + 10);
        wait_until(n + 32);

        // song_end: DONE, presses ignored, score held
        ctrl(1'b0, 1'b1);
        chk("done_playing", playing, 0);
        note_press(4'b0010, 4'b0010, 5, n);
        wait_until(n + 25); release_pads();
        chk("done_score_held", score, 99);
        chk("done_combo_held", combo, 0);
        ctrl(1'b1, 1'b0);
        chk("replay_playing", playing, 1);
        chk("replay_score", score, 0);
        ctrl(1'b1, 1'b1);
        chk("start_beats_song_end", playing, 1);

        // Asynchronous reset with windows open
        note_press(4'b0111, 4'b0001, 5, n);
        push(n + 6, 4'b0001, 4'b0001, 4'b0000, 2, 1);
        wait_until(n + 7); release_pads();
        chk("pre_reset_score", score, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_score", score, 0);
        chk("async_reset_combo", combo, 0);
        chk("async_reset_playing", playing, 0);
        chk("async_reset_pulses", {hit_pulse, perfect_pulse, miss_pulse}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_playing", playing, 0);

        // Every expected judgment must have been consumed
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_judgments: got %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
